water_origin_gen: RTL
=====================

// Module: water_origin_gen
// PURPOSE
//  Per-pixel origin generator for the scrolling 128x128 water background tile. Upstream of
//  the water sprite lookup: maps each raster pixel (px,py) to biased pixel coords plus a tile
//  origin (ox,oy) so that the lookup's in-object test always passes and (p-o) is the texel.
//  Frame-rate vertical scroll (aircraft flying forward) plus optional horizontal wave drift.
// PARAMETERS
//  COORD_W       11   width of pixel/origin coordinates
//  TILE_LOG2     7    log2 of tile edge (tile = 128 px); BIAS = 1<<TILE_LOG2
//  DRIFT_PERIOD  8    enabled frame ticks per horizontal drift step
//  DRIFT_SPAN    16   drift steps before drift direction reverses
// PORTS
//  clk        in   1        system clock, single domain
//  rst        in   1        synchronous, active-low reset
//  en         in   1        scroll enable (game running); 0 freezes scroll and drift
//  frame_tick in   1        1-cycle pulse, once per frame (start of vblank)
//  speed      in   3        vertical scroll, px/frame (0 = frozen, 7 max)
//  pix_valid  in   1        px/py valid this cycle
//  px, py     in   COORD_W  raster pixel coordinates
//  px_o, py_o out  COORD_W  biased coords: p + BIAS
//  ox, oy     out  COORD_W  tile origin; px_o-ox, py_o-oy in [0,127]
//  out_valid  out  1        registered pix_valid
//  scroll_x   out  7        current horizontal scroll offset (status)
//  scroll_y   out  7        current vertical scroll offset (status)
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): all outputs 0, scroll_x/y=0, drift state DRIFT_RIGHT,
//    frame_cnt=0, step_cnt=0. Reset has priority over every other event.
//  - Pixel path, latency 1: when pix_valid: u=(px[6:0]-scroll_x) mod 128,
//    v=(py[6:0]-scroll_y) mod 128 (7-bit wrap); px_o<=px+BIAS, py_o<=py+BIAS,
//    ox<=px+BIAS-u, oy<=py+BIAS-v. Bias guarantees ox,oy>=1 (no unsigned underflow).
//    pix_valid=0: data regs hold, out_valid<=0. out_valid<=pix_valid each cycle.
//  - Scroll path: on frame_tick&en: scroll_y<=scroll_y+speed mod 128 (wraps 127->0 freely).
//    frame_tick with en=0: no scroll, counters hold.
//  - Same-cycle frame_tick and pix_valid: pixel uses pre-update scroll; new value seen next cycle.
//  - Drift FSM (DRIFT_RIGHT/DRIFT_LEFT): frame_cnt counts frame_tick&en, 0..DRIFT_PERIOD-1;
//    on wrap, scroll_x +1 (RIGHT) or -1 (LEFT) mod 128, step_cnt++; step taking step_cnt to
//    DRIFT_SPAN flips state, step_cnt<=0. en=0 holds state and counters.
//  - Widths: all origin arithmetic in COORD_W bits; px,py must be < 2^COORD_W-BIAS.
// CONFIGURATION
//  WATER_DRIFT_EN defined: drift FSM and counters present as above.
//  Undefined: no FSM/counters; scroll_x tied to 0, u = px[6:0]; vertical scroll unchanged.
// STRUCTURE
//  Package water_pkg: COORD_W, TILE_LOG2, TILE_SIZE, BIAS constants; drift_state_t enum
//  {DRIFT_RIGHT, DRIFT_LEFT}.
//  Sub-module water_scroll_ctrl: frame-rate scroll_y accumulator + drift FSM, outputs
//  scroll_x/scroll_y; water_origin_gen holds only the registered pixel path.
// TESTING
//  1 rst=0 two cycles mid-stream -> all outputs 0, scroll_x=scroll_y=0, out_valid=0.
//  2 speed=0,en=1, px=5,py=3 valid -> next cycle px_o=133,py_o=131,ox=128,oy=128,out_valid=1.
//  3 speed=3, two frame_ticks -> scroll_y=6; py=2 -> py_o=130, oy=6 (texel row 124).
//  4 speed=7, 19 frame_ticks -> scroll_y=5 (133 mod 128); random px/py: p_o-o always <=127.
//  5 WATER_DRIFT_EN, DRIFT_PERIOD=2,DRIFT_SPAN=3: 6 ticks -> scroll_x=3, DRIFT_LEFT;
//    2 more -> 2. Macro off: scroll_x stays 0 after 100 ticks.
//  6 frame_tick with en=0 -> no change; frame_tick with rst=0 same cycle -> reset values.

Source files
------------

// File: rtl/water_pkg.sv
// Shared constants and drift state type for the scrolling water background tile.
// Optional horizontal drift is compiled in only when WATER_DRIFT_EN is defined.
package water_pkg;

  localparam int COORD_W      = 11;
  localparam int TILE_LOG2    = 7;
  localparam int TILE_SIZE    = 1 << TILE_LOG2;
  localparam int BIAS         = TILE_SIZE;
  localparam int DRIFT_PERIOD = 8;
  localparam int DRIFT_SPAN   = 16;

  typedef enum logic {
    DRIFT_RIGHT = 1'b0,
    DRIFT_LEFT  = 1'b1
  } drift_state_t;

endpackage

// File: rtl/water_scroll_ctrl.sv
// Frame-rate scroll accumulator: vertical scroll_y plus, with WATER_DRIFT_EN defined,
// a ping-pong horizontal drift FSM; otherwise scroll_x is held at 0.
module water_scroll_ctrl #(
  parameter int TILE_LOG2    = water_pkg::TILE_LOG2,
  parameter int DRIFT_PERIOD = water_pkg::DRIFT_PERIOD,
  parameter int DRIFT_SPAN   = water_pkg::DRIFT_SPAN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 frame_tick,
  input  logic [2:0]           speed,
  output logic [TILE_LOG2-1:0] scroll_x,
  output logic [TILE_LOG2-1:0] scroll_y
);
  import water_pkg::*;

  logic                 adv;
  logic [TILE_LOG2-1:0] scroll_y_q, scroll_y_d;

  assign adv      = frame_tick & en;
  assign scroll_y = scroll_y_q;

  // Vertical scroll wraps freely at the tile edge.
  always_comb begin
    scroll_y_d = scroll_y_q;
    if (adv) begin
      scroll_y_d = scroll_y_q + {{(TILE_LOG2-3){1'b0}}, speed};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scroll_y_q <= '0;
    end else begin
      scroll_y_q <= scroll_y_d;
    end
  end

`ifdef WATER_DRIFT_EN
  localparam int FC_W = $clog2(DRIFT_PERIOD + 1);
  localparam int SC_W = $clog2(DRIFT_SPAN + 1);

  drift_state_t         state_q, state_d;
  logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [SC_W-1:0]      step_cnt_q, step_cnt_d;
  logic [TILE_LOG2-1:0] scroll_x_q, scroll_x_d;
  logic [TILE_LOG2-1:0] x_delta;
  logic                 step;
  logic                 span_done;

  assign step      = adv && (frame_cnt_q == FC_W'(DRIFT_PERIOD - 1));
  assign span_done = step && (step_cnt_q == SC_W'(DRIFT_SPAN - 1));
  assign scroll_x  = scroll_x_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DRIFT_RIGHT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DRIFT_RIGHT: if (span_done) state_d = DRIFT_LEFT;
      DRIFT_LEFT:  if (span_done) state_d = DRIFT_RIGHT;
      default:     state_d = DRIFT_RIGHT;
    endcase
  end

  // Moving left is a modulo add of all-ones.
  always_comb begin
    x_delta = (state_q == DRIFT_LEFT) ? '1 : TILE_LOG2'(1);
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    step_cnt_d  = step_cnt_q;
    scroll_x_d  = scroll_x_q;
    if (adv) begin
      frame_cnt_d = step ? '0 : frame_cnt_q + FC_W'(1);
    end
    if (step) begin
      scroll_x_d = scroll_x_q + x_delta;
      step_cnt_d = span_done ? '0 : step_cnt_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      step_cnt_q  <= '0;
      scroll_x_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      step_cnt_q  <= step_cnt_d;
      scroll_x_q  <= scroll_x_d;
    end
  end
`else
  assign scroll_x = '0;
`endif

endmodule

// File: rtl/water_origin_gen.sv
// Per-pixel tile origin generator for the water background (1-cycle latency).
// Horizontal drift is enabled by defining WATER_DRIFT_EN.
module water_origin_gen #(
  parameter int COORD_W      = water_pkg::COORD_W,
  parameter int TILE_LOG2    = water_pkg::TILE_LOG2,
  parameter int DRIFT_PERIOD = water_pkg::DRIFT_PERIOD,
  parameter int DRIFT_SPAN   = water_pkg::DRIFT_SPAN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 frame_tick,
  input  logic [2:0]           speed,
  input  logic                 pix_valid,
  input  logic [COORD_W-1:0]   px,
  input  logic [COORD_W-1:0]   py,
  output logic [COORD_W-1:0]   px_o,
  output logic [COORD_W-1:0]   py_o,
  output logic [COORD_W-1:0]   ox,
  output logic [COORD_W-1:0]   oy,
  output logic                 out_valid,
  output logic [TILE_LOG2-1:0] scroll_x,
  output logic [TILE_LOG2-1:0] scroll_y
);
  import water_pkg::*;

  localparam logic [COORD_W-1:0] BIAS_C = COORD_W'(1) << TILE_LOG2;

  logic [TILE_LOG2-1:0] u, v;
  logic [COORD_W-1:0]   px_o_q, py_o_q, ox_q, oy_q;
  logic [COORD_W-1:0]   px_o_d, py_o_d, ox_d, oy_d;
  logic                 valid_q;

  water_scroll_ctrl #(
    .TILE_LOG2    (TILE_LOG2),
    .DRIFT_PERIOD (DRIFT_PERIOD),
    .DRIFT_SPAN   (DRIFT_SPAN)
  ) u_scroll (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frame_tick (frame_tick),
    .speed      (speed),
    .scroll_x   (scroll_x),
    .scroll_y   (scroll_y)
  );

  // Texel (u,v) wraps in 7 bits; the bias keeps p+BIAS-texel strictly positive.
  always_comb begin
    u      = px[TILE_LOG2-1:0] - scroll_x;
    v      = py[TILE_LOG2-1:0] - scroll_y;
    px_o_d = px + BIAS_C;
    py_o_d = py + BIAS_C;
    ox_d   = px_o_d - {{(COORD_W-TILE_LOG2){1'b0}}, u};
    oy_d   = py_o_d - {{(COORD_W-TILE_LOG2){1'b0}}, v};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      px_o_q  <= '0;
      py_o_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pix_valid;
      if (pix_valid) begin
        px_o_q <= px_o_d;
        py_o_q <= py_o_d;
        ox_q   <= ox_d;
        oy_q   <= oy_d;
      end
    end
  end

  assign px_o      = px_o_q;
  assign py_o      = py_o_q;
  assign ox        = ox_q;
  assign oy        = oy_q;
  assign out_valid = valid_q;

endmodule
